// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port.
// Ports: req0 = ALU, req1 = load; rf_* = bank write; fwd* = in-flight match.
module regbank_wb_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              fwd1_o,
    output logic              fwd2_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic              last_grant;
    logic              gnt0;
    logic              gnt1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grants are masked by rst_n so nothing is accepted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !stall_i) begin
            gnt0 = req0_valid_i && (!req1_valid_i || last_grant);
            gnt1 = req1_valid_i && (!req0_valid_i || !last_grant);
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign xfer         = gnt0 || gnt1;
    assign sel_addr     = gnt1 ? req1_addr_i : req0_addr_i;
    assign sel_data     = gnt1 ? req1_data_i : req0_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (xfer) begin
            last_grant <= gnt1;
            rf_waddr_o <= sel_addr;
            rf_wdata_o <= sel_data;
            // Address 0 is accepted but suppressed at the bank.
            rf_we_o    <= !(ZERO_REG_EN && (sel_addr == '0));
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

    assign fwd1_o     = rf_we_o && (rf_waddr_o == rs1_addr_i);
    assign fwd2_o     = rf_we_o && (rf_waddr_o == rs2_addr_i);
    assign fwd_data_o = rf_wdata_o;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter.
// Scoreboard queue of expected bank writes, directed steps.
module tb_regbank_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        req0_valid_i = 1'b0;
    logic [4:0]  req0_addr_i = '0;
    logic [31:0] req0_data_i = '0;
    logic        req0_ready_o;
    logic        req1_valid_i = 1'b0;
    logic [4:0]  req1_addr_i = '0;
    logic [31:0] req1_data_i = '0;
    logic        req1_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        fwd1_o;
    logic        fwd2_o;
    logic [31:0] fwd_data_o;

    regbank_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .fwd1_o(fwd1_o), .fwd2_o(fwd2_o), .fwd_data_o(fwd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic m_last = 1'b1;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int   gseq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check grant, clock, check output stage.
    task automatic cyc(input string tag, input logic s,
                       input logic v0, input logic [4:0] a0,
                       input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1,
                       input logic [31:0] d1,
                       input logic [4:0] r1, input logic [4:0] r2);
        logic g0, g1, ewe;
        wr_t  w;
        stall_i = s;
        req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
        req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
        rs1_addr_i = r1; rs2_addr_i = r2;
        #1;
        g0 = !s && v0 && (!v1 || m_last);
        g1 = !s && v1 && (!v0 || !m_last);
        chk({tag, "_rdy0"}, 32'(req0_ready_o), 32'(g0));
        chk({tag, "_rdy1"}, 32'(req1_ready_o), 32'(g1));
        if (g0 || g1) begin
            w.addr = g1 ? a1 : a0;
            w.data = g1 ? d1 : d0;
            w.we   = (w.addr != 5'd0);
            sb.push_back(w);
            m_last = g1;
            gseq.push_back(g1 ? 1 : 0);
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            w = sb.pop_front();
            m_addr = w.addr;
            m_data = w.data;
            ewe = w.we;
        end else begin
            ewe = 1'b0;
        end
        chk({tag, "_we"}, 32'(rf_we_o), 32'(ewe));
        chk({tag, "_waddr"}, 32'(rf_waddr_o), 32'(m_addr));
        chk({tag, "_wdata"}, rf_wdata_o, m_data);
        chk({tag, "_fwd1"}, 32'(fwd1_o), 32'(ewe && (m_addr == r1)));
        chk({tag, "_fwd2"}, 32'(fwd2_o), 32'(ewe && (m_addr == r2)));
        chk({tag, "_fdata"}, fwd_data_o, m_data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        m_last = 1'b1;
        m_addr = '0;
        m_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with a request pending to see ready held low.
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        #3;
        chk("rst_rdy0", 32'(req0_ready_o), 32'd0);
        chk("rst_rdy1", 32'(req1_ready_o), 32'd0);
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single ALU write.
        cyc("t1", 0, 1, 5, 32'h11, 0, 0, 0, 0, 0);
        chk("t1_waddr5", 32'(rf_waddr_o), 32'd5);
        cyc("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_hold", rf_wdata_o, 32'h11);

        // 2: conflict from fresh reset alternates 0,1,0,1.
        do_reset();
        gseq.delete();
        for (int i = 0; i < 4; i++) begin
            cyc("t2", 0, 1, 1, 32'hA0 + 32'(i), 1, 2, 32'hB0 + 32'(i), 0, 0);
            chk("t2_addr_seq", 32'(rf_waddr_o), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        chk("t2_ngrants", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < gseq.size(); i++)
            chk("t2_gorder", 32'(gseq[i]), 32'(i % 2));

        // 3: load to x0 accepted but never written.
        cyc("t3", 0, 0, 0, 0, 1, 0, 32'hFF, 0, 0);
        chk("t3_we0", 32'(rf_we_o), 32'd0);

        // 4: stall with both valid, then release.
        for (int i = 0; i < 3; i++)
            cyc("t4_stall", 1, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
        // last grant was port 1 (t3), so port 0 wins first.
        cyc("t4_rel", 0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
        chk("t4_first", 32'(rf_waddr_o), 32'd3);
        cyc("t4_next", 0, 0, 3, 32'h33, 1, 4, 32'h44, 0, 0);

        // 5: forwarding on an in-flight write.
        cyc("t5", 0, 1, 7, 32'hABCD, 0, 0, 0, 7, 3);
        chk("t5_fwd1", 32'(fwd1_o), 32'd1);
        chk("t5_fwd2", 32'(fwd2_o), 32'd0);
        chk("t5_fdata", fwd_data_o, 32'hABCD);

        // 6: reset mid-operation drops the pending write.
        cyc("t6a", 0, 1, 9, 32'h99, 0, 0, 0, 0, 0);
        req0_valid_i = 1'b1; req0_addr_i = 5'd10; req0_data_i = 32'h1010;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_we", 32'(rf_we_o), 32'd0);
        chk("t6_async_wa", 32'(rf_waddr_o), 32'd0);
        chk("t6_rdy_rst", 32'(req0_ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("t6_nocommit", 32'(rf_wdata_o), 32'd0);
        sb.delete();
        m_last = 1'b1; m_addr = '0; m_data = '0;
        rst_n = 1'b1;
        cyc("t6b", 0, 1, 12, 32'hC0, 1, 13, 32'hD0, 0, 0);
        chk("t6_p0win", 32'(rf_waddr_o), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
